lab3_mem_responder: RTL and testbench

- Word-addressed test-memory responder: the memory end of the 4B request/response interface that the cache's DMA drives.
- Accepts mem_req_4B_t requests (read/write/init) on a val/rdy port.
- Performs them in order against an internal word array.
- Returns mem_resp_4B_t responses after a fixed programmable latency, buffered so that response backpressure never drops data.
- Sits between the cache (via DMA) and the test harness in lab3 cache simulations.

---
 rtl/lab3_mem_responder.sv | 127 ++++++++++++
 tb/tb_lab3_mem_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lab3_mem_responder.sv
// rtl/lab3_mem_responder.sv - word-addressed test memory behind a 4B val/rdy request/response port
// Requests execute in order at accept; responses pass through a fixed-latency pipeline into a response FIFO.
module lab3_mem_responder #(
    parameter int NUM_WORDS = 256,
    parameter int LATENCY   = 2,
    parameter int DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    input  logic [76:0] memreq_msg,
    output logic        memresp_val,
    input  logic        memresp_rdy,
    output logic [46:0] memresp_msg
);
    localparam int AW = $clog2(NUM_WORDS);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]        r_mem [NUM_WORDS];
    logic [LATENCY-1:0] r_pipe_val;
    logic [46:0]        r_pipe_msg [LATENCY];
    logic [46:0]        r_fifo [DEPTH];
    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;

    logic [2:0]  w_type;
    logic [7:0]  w_opaque;
    logic [31:0] w_addr;
    logic [1:0]  w_len;
    logic [31:0] w_data;
    logic [AW-1:0] w_idx;
    logic [4:0]  w_shift;
    logic [2:0]  w_nbytes;
    logic [31:0] w_cur;
    logic [31:0] w_wsh;
    logic [31:0] w_rsh;
    logic [31:0] w_wr_word;
    logic [31:0] w_rd_data;
    logic [31:0] w_resp_data;
    logic        w_is_wr;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic [CW:0] w_pipe_cnt;
    logic [CW:0] w_outstanding;

    assign w_type   = memreq_msg[76:74];
    assign w_opaque = memreq_msg[73:66];
    assign w_addr   = memreq_msg[65:34];
    assign w_len    = memreq_msg[33:32];
    assign w_data   = memreq_msg[31:0];

    // Upper address bits are ignored, so the array aliases across the address space.
    assign w_idx    = w_addr[AW+1:2];
    assign w_shift  = {w_addr[1:0], 3'b000};
    assign w_nbytes = (w_len == 2'd0) ? 3'd4 : {1'b0, w_len};
    assign w_cur    = r_mem[w_idx];
    assign w_is_wr  = (w_type == 3'd1) || (w_type == 3'd2);

    always_comb begin
        w_wsh     = w_data << w_shift;
        w_rsh     = w_cur >> w_shift;
        w_wr_word = w_cur;
        w_rd_data = '0;
        for (int k = 0; k < 4; k++) begin
            // Lanes past byte 3 simply fall off the shift: no wrap into the next word.
            if (k >= int'(w_addr[1:0]) && k < int'(w_addr[1:0]) + int'(w_nbytes))
                w_wr_word[8*k +: 8] = w_wsh[8*k +: 8];
            if (k < int'(w_nbytes))
                w_rd_data[8*k +: 8] = w_rsh[8*k +: 8];
        end
    end

    assign w_resp_data = (w_type == 3'd0) ? w_rd_data : 32'd0;

    always_comb begin
        w_pipe_cnt = '0;
        for (int i = 0; i < LATENCY; i++)
            w_pipe_cnt = w_pipe_cnt + {{CW{1'b0}}, r_pipe_val[i]};
    end

    assign w_outstanding = w_pipe_cnt + {1'b0, r_count};
    assign memreq_rdy    = reset && (w_outstanding < (CW+1)'(DEPTH));
    assign w_accept      = memreq_val && memreq_rdy;
    assign w_push        = r_pipe_val[LATENCY-1];
    assign memresp_val   = (r_count != '0);
    assign memresp_msg   = r_fifo[r_rptr];
    assign w_pop         = memresp_val && memresp_rdy;

    always_ff @(posedge clk) begin
        if (w_accept && w_is_wr)
            r_mem[w_idx] <= w_wr_word;
    end

    always_ff @(posedge clk) begin
        r_pipe_msg[0] <= {w_type, w_opaque, 2'b00, w_len, w_resp_data};
        for (int i = 1; i < LATENCY; i++)
            r_pipe_msg[i] <= r_pipe_msg[i-1];
        if (w_push)
            r_fifo[r_wptr] <= r_pipe_msg[LATENCY-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pipe_val <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_pipe_val[0] <= w_accept;
            for (int i = 1; i < LATENCY; i++)
                r_pipe_val[i] <= r_pipe_val[i-1];
            if (w_push)
                r_wptr <= (r_wptr == PW'(DEPTH-1)) ? '0 : r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= (r_rptr == PW'(DEPTH-1)) ? '0 : r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_lab3_mem_responder.sv
// tb/tb_lab3_mem_responder.sv - scoreboard bench for lab3_mem_responder
// Expected responses come from a byte-lane memory model and are queued at accept time.
module tb_lab3_mem_responder;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memreq_val = 1'b0;
    logic        memreq_rdy;
    logic [76:0] memreq_msg = '0;
    logic        memresp_val;
    logic        memresp_rdy = 1'b0;
    logic [46:0] memresp_msg;

    lab3_mem_responder #(.NUM_WORDS(256), .LATENCY(LAT), .DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memreq_msg  (memreq_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .memresp_msg (memresp_msg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [46:0] msg;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] mdl [256];
    logic [31:0] d_exp;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          lat;
    int          nacc;
    int          c0;
    bit          exact_lat = 1'b0;
    bit          held = 1'b0;
    logic [46:0] held_msg;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_exec(input logic [2:0] t, input logic [31:0] a,
                                               input logic [1:0] l, input logic [31:0] d);
        int          idx = int'(a[9:2]);
        int          off = int'(a[1:0]);
        int          nb  = (l == 2'd0) ? 4 : int'(l);
        logic [31:0] w   = mdl[idx];
        logic [31:0] r   = '0;
        for (int b = 0; b < nb; b++) begin
            if (off + b < 4) begin
                if (t == 3'd1 || t == 3'd2) w[8*(off+b) +: 8] = d[8*b +: 8];
                else                        r[8*b +: 8] = w[8*(off+b) +: 8];
            end
        end
        if (t == 3'd1 || t == 3'd2) begin
            mdl[idx] = w;
            return 32'd0;
        end
        return (t == 3'd0) ? r : 32'd0;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_val", 64'(memresp_val), 64'd1);
                chk("hold_msg", 64'(memresp_msg), 64'(held_msg));
            end
            held     = memresp_val && !memresp_rdy;
            held_msg = memresp_msg;
            if (memresp_val && memresp_rdy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    e   = sb.pop_front();
                    lat = cyc - e.acc;
                    chk("resp_msg", 64'(memresp_msg), 64'(e.msg));
                    if (exact_lat) chk("resp_latency", 64'(lat), 64'(LAT));
                    else           chk("resp_latency_min", 64'(lat >= LAT), 64'd1);
                end
            end
            if (memreq_val && memreq_rdy) begin
                d_exp = model_exec(memreq_msg[76:74], memreq_msg[65:34], memreq_msg[33:32], memreq_msg[31:0]);
                sb.push_back('{{memreq_msg[76:74], memreq_msg[73:66], 2'b00, memreq_msg[33:32], d_exp}, cyc + 1});
            end
        end
    end

    task automatic send(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                        input logic [1:0] l, input logic [31:0] d);
        bit ok = 1'b0;
        memreq_msg = {t, op, a, l, d};
        memreq_val = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (memreq_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        memreq_val = 1'b0;
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        chk("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_val", 64'(memresp_val), 64'd0);
        chk("rst_req_rdy", 64'(memreq_rdy), 64'd0);
        reset = 1'b1;
        #1;
        chk("post_rst_req_rdy", 64'(memreq_rdy), 64'd1);
        chk("post_rst_resp_val", 64'(memresp_val), 64'd0);
        memresp_rdy = 1'b1;
        @(posedge clk);
        #1;

        exact_lat = 1'b1;
        send(3'd2, 8'h01, 32'h100, 2'd0, 32'hDEADBEEF);
        send(3'd0, 8'h05, 32'h100, 2'd0, 32'h0);
        drain();

        c0 = cyc;
        send(3'd1, 8'h02, 32'h200, 2'd0, 32'h11223344);
        send(3'd0, 8'h03, 32'h200, 2'd0, 32'h0);
        chk("b2b_accept_cycles", 64'(cyc - c0), 64'd2);
        drain();
        exact_lat = 1'b0;

        send(3'd2, 8'h10, 32'h300, 2'd0, 32'h0);
        send(3'd1, 8'h11, 32'h301, 2'd2, 32'h0000AABB);
        send(3'd0, 8'h12, 32'h300, 2'd0, 32'h0);
        send(3'd0, 8'h13, 32'h302, 2'd1, 32'h0);
        send(3'd0, 8'h14, 32'h303, 2'd2, 32'h0);
        send(3'd3, 8'h15, 32'h100, 2'd0, 32'h0);
        send(3'd7, 8'h16, 32'h100, 2'd0, 32'h12345678);
        drain();

        memresp_rdy = 1'b0;
        nacc = 0;
        memreq_val = 1'b1;
        for (int i = 0; i < 10; i++) begin
            memreq_msg = {3'd0, 8'(nacc), 32'h100, 2'd0, 32'h0};
            @(negedge clk);
            if (memreq_rdy) nacc++;
            @(posedge clk);
            #1;
            if (nacc >= 6) break;
        end
        memreq_val = 1'b0;
        chk("bp_accepted", 64'(nacc), 64'd4);
        chk("bp_rdy_low", 64'(memreq_rdy), 64'd0);
        chk("bp_resp_val", 64'(memresp_val), 64'd1);
        memresp_rdy = 1'b1;
        #1;
        chk("bp_rdy_before_pop", 64'(memreq_rdy), 64'd0);
        @(posedge clk);
        #1;
        chk("bp_rdy_after_pop", 64'(memreq_rdy), 64'd1);
        drain();

        send(3'd1, 8'h30, 32'h00000400, 2'd0, 32'h00000055);
        send(3'd0, 8'h31, 32'h00000000, 2'd0, 32'h0);
        drain();

        memresp_rdy = 1'b0;
        send(3'd0, 8'h40, 32'h100, 2'd0, 32'h0);
        send(3'd0, 8'h41, 32'h200, 2'd0, 32'h0);
        reset = 1'b0;
        #1;
        chk("rst_mid_val", 64'(memresp_val), 64'd0);
        chk("rst_mid_rdy", 64'(memreq_rdy), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        memresp_rdy = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_no_stale", 64'(memresp_val), 64'd0);
        send(3'd0, 8'h42, 32'h200, 2'd0, 32'h0);
        send(3'd0, 8'h43, 32'h100, 2'd0, 32'h0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
